// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte requesters, the arbiter and the single uart_tx serializer.
// Requester side: a byte moves on a rising edge where req_valid[i] & req_ready[i]; serializer side: it captures tx_data where tx_send & tx_ready.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_send;
  logic                 tx_ready;
  logic [2:0]           owner;
  logic                 busy;
  logic                 timeout;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_send, owner, busy, timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_send, owner, busy, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx serializer between NUM_REQ byte streams.
// A granted requester keeps the serializer until its last byte is out or the NEXT-state hold timeout expires.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus,
  output logic [1:0]       o_dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NEXT = 2'd1,
    S_SEND = 2'd2,
    S_BUSY = 2'd3
  } state_t;

  localparam logic [2:0]  LAST_IDX = 3'(NUM_REQ - 1);
  localparam logic [15:0] TMO_VAL  = 16'(TIMEOUT_CYC);
  localparam bit          TMO_EN   = (TIMEOUT_CYC != 0);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_owner;
  logic [2:0]  r_ptr;
  logic [15:0] r_cnt;
  logic        r_last;
  logic [7:0]  r_tx_data;
  logic        r_timeout;

  logic        w_any;
  logic [2:0]  w_win;
  logic [2:0]  w_owner_inc;
  logic [15:0] w_cnt_inc;
  logic        w_own_valid;
  logic        w_own_last;
  logic [7:0]  w_own_data;
  logic        w_tmo;

  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == 3'(i)) begin
        w_own_valid = bus.req_valid[i];
        w_own_last  = bus.req_last[i];
        w_own_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  // Lowest index at or above ptr wins; otherwise lowest index below ptr (the wrap).
  always_comb begin
    w_any = |bus.req_valid;
    w_win = r_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (3'(i) < r_ptr)) w_win = 3'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (3'(i) >= r_ptr)) w_win = 3'(i);
    end
  end

  assign w_owner_inc = (r_owner == LAST_IDX) ? 3'd0 : r_owner + 3'd1;
  assign w_cnt_inc   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_tmo       = TMO_EN && (r_state == S_NEXT) && !w_own_valid && (w_cnt_inc == TMO_VAL);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_NEXT;
      S_NEXT: begin
        if (w_own_valid) w_next = S_SEND;
        else if (w_tmo)  w_next = S_IDLE;
      end
      S_SEND: if (bus.tx_ready) w_next = S_BUSY;
      S_BUSY: if (bus.tx_ready) w_next = r_last ? S_IDLE : S_NEXT;
      default: w_next = S_IDLE;
    endcase
  end

  // The idle counter only moves in NEXT, so it is still zero when BUSY hands back to NEXT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner   <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_last    <= 1'b0;
      r_tx_data <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_cnt   <= '0;
          end
        end
        S_NEXT: begin
          if (w_own_valid) begin
            r_tx_data <= w_own_data;
            r_last    <= w_own_last;
            r_cnt     <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_tmo) r_ptr <= w_owner_inc;
          end
        end
        S_BUSY: begin
          if (bus.tx_ready && r_last) r_ptr <= w_owner_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((r_state == S_NEXT) && (r_owner == 3'(i))) bus.req_ready[i] = 1'b1;
    end
    bus.tx_send = (r_state == S_SEND);
    bus.tx_data = r_tx_data;
    bus.owner   = r_owner;
    bus.busy    = (r_state != S_IDLE);
    bus.timeout = r_timeout;
    o_dbg_state = r_state;
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: one instance without hold timeout fed by queued requesters and a
// 40-cycle frame serializer model, one instance with a 20-cycle timeout driven directly.
module tb_uart_tx_arbiter;
  localparam int FRAME = 40;

  logic clk;
  logic reset;
  logic [1:0] dbg0;
  logic [1:0] dbg1;
  int cyc;

  uart_tx_arbiter_if #(.NUM_REQ(4)) if0 ();
  uart_tx_arbiter_if #(.NUM_REQ(4)) if1 ();

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(0)) u_dut (
    .clk(clk), .reset(reset), .bus(if0.slave), .o_dbg_state(dbg0)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(20)) u_dut_tmo (
    .clk(clk), .reset(reset), .bus(if1.slave), .o_dbg_state(dbg1)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- serializer model for instance 0 ----------------
  int         s_busy;
  int         s_wait;
  int         hold_n;
  logic       cap_evt;
  logic [10:0] cap_word;
  int         cap_cyc;

  assign if0.tx_ready = (s_busy == 0) && (s_wait >= hold_n);

  always @(posedge clk) begin
    if (reset) begin
      s_busy  <= 0;
      s_wait  <= 0;
      cap_evt <= 1'b0;
    end else begin
      cap_evt <= 1'b0;
      if (s_busy > 0) begin
        s_busy <= s_busy - 1;
      end else if (if0.tx_send && (s_wait < hold_n)) begin
        s_wait <= s_wait + 1;
      end else if (if0.tx_send) begin
        s_busy   <= FRAME;
        s_wait   <= 0;
        cap_evt  <= 1'b1;
        cap_word <= {if0.owner, if0.tx_data};
        cap_cyc  <= cyc;
      end
    end
  end

  // ---------------- serializer model for instance 1 ----------------
  int         t_busy;
  int         t_caps;
  logic [7:0] t_cap;

  assign if1.tx_ready = (t_busy == 0);

  always @(posedge clk) begin
    if (reset) begin
      t_busy <= 0;
    end else if (t_busy > 0) begin
      t_busy <= t_busy - 1;
    end else if (if1.tx_send) begin
      t_busy <= 10;
      t_cap  <= if1.tx_data;
      t_caps <= t_caps + 1;
    end
  end

  // ---------------- requester driver for instance 0 ----------------
  logic [8:0] rq[4][$];
  int         acc_cnt[4];

  initial begin
    logic [3:0] acc;
    if0.req_valid = '0;
    if0.req_data  = '0;
    if0.req_last  = '0;
    for (int i = 0; i < 4; i++) acc_cnt[i] = 0;
    forever begin
      @(negedge clk);
      acc = if0.req_valid & if0.req_ready & {4{~reset}};
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && (rq[i].size() > 0)) begin
          void'(rq[i].pop_front());
          acc_cnt[i]++;
        end
        if (rq[i].size() > 0) begin
          if0.req_valid[i]      = 1'b1;
          if0.req_data[8*i +: 8] = rq[i][0][7:0];
          if0.req_last[i]       = rq[i][0][8];
        end else begin
          if0.req_valid[i] = 1'b0;
          if0.req_last[i]  = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard and monitors ----------------
  logic [10:0] exp_q[$];
  int          cap_t[$];
  int          wq[$];
  int          run_len;
  int          stab_err;
  int          tmo_cnt0;
  int          tmo_cnt1;
  int          r0_seen;
  logic        stall_mon;
  logic        prev_send;
  logic [7:0]  prev_data;

  initial begin
    run_len   = 0;
    stab_err  = 0;
    tmo_cnt0  = 0;
    tmo_cnt1  = 0;
    r0_seen   = 0;
    stall_mon = 1'b0;
    prev_send = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (cap_evt) begin
        cap_t.push_back(cap_cyc);
        if (exp_q.size() == 0) chk("sb_unexpected_frame", 32'(exp_q.size()), 32'd1);
        else                   chk("sb_frame", 32'(cap_word), 32'(exp_q.pop_front()));
      end
      if (if0.tx_send) begin
        run_len++;
        if (prev_send && (if0.tx_data != prev_data)) stab_err++;
      end else if (prev_send) begin
        wq.push_back(run_len);
        run_len = 0;
      end
      prev_send = if0.tx_send;
      prev_data = if0.tx_data;
      if (if0.timeout) tmo_cnt0++;
      if (if1.timeout) tmo_cnt1++;
      if (stall_mon && if0.req_ready[0]) r0_seen++;
    end
  end

  // ---------------- helper tasks ----------------
  task automatic drive_reset(input int n);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic push_byte(input int r, input logic last, input logic [7:0] d);
    rq[r].push_back({last, d});
    exp_q.push_back({3'(r), d});
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    int pending;
    n = 0;
    pending = 1;
    while ((pending != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
      pending = exp_q.size() + rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size()
              + int'(if0.busy) + s_busy;
    end
    chk(tag, 32'(pending), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t0, t1, t2, a2, n;
    reset  = 1'b1;
    hold_n = 0;
    if1.req_valid = '0;
    if1.req_data  = '0;
    if1.req_last  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    chk("rst_tx_send",   32'(if0.tx_send),   32'd0);
    chk("rst_tx_data",   32'(if0.tx_data),   32'd0);
    chk("rst_req_ready", 32'(if0.req_ready), 32'd0);
    chk("rst_owner",     32'(if0.owner),     32'd0);
    chk("rst_busy",      32'(if0.busy),      32'd0);
    chk("rst_timeout",   32'(if0.timeout),   32'd0);
    chk("rst_state",     32'(dbg0),          32'd0);

    // Contention: four 2-byte packets from reset, strict rotation 0..3.
    cap_t.delete();
    for (int i = 0; i < 4; i++) begin
      rq[i].push_back({1'b0, 8'(8'h10 + i)});
      rq[i].push_back({1'b1, 8'(8'h20 + i)});
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({3'(i), 8'(8'h10 + i)});
      exp_q.push_back({3'(i), 8'(8'h20 + i)});
    end
    wait_drain("drain_contention", 3000);
    if (cap_t.size() >= 3) begin
      chk("gap_in_packet",   32'(cap_t[1] - cap_t[0]), 32'(FRAME + 3));
      chk("gap_next_packet", 32'(cap_t[2] - cap_t[1]), 32'(FRAME + 4));
    end else begin
      chk("contention_frames", 32'(cap_t.size()), 32'd8);
    end

    // Single byte from requester 2, with grant/accept latency.
    a2 = acc_cnt[2];
    push_byte(2, 1'b1, 8'hA5);
    n = 0;
    while (!if0.req_valid[2] && (n < 10)) begin @(negedge clk); n++; end
    chk("idle_ready_zero", 32'(if0.req_ready), 32'd0);
    t0 = cyc;
    n = 0;
    while (!if0.busy && (n < 10)) begin @(negedge clk); n++; end
    t1 = cyc;
    chk("grant_latency", 32'(t1 - t0), 32'd1);
    chk("grant_owner",   32'(if0.owner), 32'd2);
    chk("next_ready",    32'(if0.req_ready), 32'b0100);
    n = 0;
    while (!if0.tx_send && (n < 10)) begin @(negedge clk); n++; end
    t2 = cyc;
    chk("send_latency", 32'(t2 - t1), 32'd1);
    wait_drain("drain_single", 200);
    chk("single_accepts",  32'(acc_cnt[2] - a2), 32'd1);
    chk("owner_held_idle", 32'(if0.owner), 32'd2);

    // Search restarts after requester 2: requester 3 beats requester 0.
    push_byte(3, 1'b1, 8'hB3);
    push_byte(0, 1'b1, 8'hB0);
    exp_q.delete();
    exp_q.push_back({3'd3, 8'hB3});
    exp_q.push_back({3'd0, 8'hB0});
    wait_drain("drain_ptr", 400);

    // Stall mid-packet: requester 1 goes silent for 100 cycles while holding the lock.
    rq[1].push_back({1'b0, 8'h31});
    exp_q.push_back({3'd1, 8'h31});
    n = 0;
    while ((acc_cnt[1] == 0 || if0.owner != 3'd1) && (n < 30)) begin @(negedge clk); n++; end
    rq[0].push_back({1'b1, 8'h01});
    stall_mon = 1'b1;
    repeat (100) @(negedge clk);
    stall_mon = 1'b0;
    chk("stall_r0_held_off", 32'(r0_seen), 32'd0);
    rq[1].push_back({1'b1, 8'h32});
    exp_q.push_back({3'd1, 8'h32});
    exp_q.push_back({3'd0, 8'h01});
    wait_drain("drain_stall", 600);
    chk("stall_no_timeout", 32'(tmo_cnt0), 32'd0);

    // Serializer holds tx_ready low 7 extra cycles on the first byte.
    cap_t.delete();
    wq.delete();
    stab_err = 0;
    hold_n = 7;
    push_byte(1, 1'b0, 8'h51);
    push_byte(1, 1'b1, 8'h52);
    n = 0;
    while ((cap_t.size() == 0) && (n < 100)) begin @(negedge clk); n++; end
    hold_n = 0;
    wait_drain("drain_hold", 400);
    chk("hold_frames", 32'(cap_t.size()), 32'd2);
    chk("hold_stable", 32'(stab_err), 32'd0);
    if (wq.size() == 2) begin
      chk("send_width_held", 32'(wq[0]), 32'd8);
      chk("send_width_free", 32'(wq[1]), 32'd1);
    end else begin
      chk("send_pulses", 32'(wq.size()), 32'd2);
    end
    if (cap_t.size() == 2) chk("hold_gap", 32'(cap_t[1] - cap_t[0]), 32'(FRAME + 3));

    // Reset during bit 4 of a frame, then rotation restarts at requester 0.
    cap_t.delete();
    push_byte(2, 1'b1, 8'h62);
    n = 0;
    while ((cap_t.size() == 0) && (n < 100)) begin @(negedge clk); n++; end
    repeat (21) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_send",   32'(if0.tx_send),   32'd0);
    chk("mid_rst_tx_data",   32'(if0.tx_data),   32'd0);
    chk("mid_rst_req_ready", 32'(if0.req_ready), 32'd0);
    chk("mid_rst_owner",     32'(if0.owner),     32'd0);
    chk("mid_rst_busy",      32'(if0.busy),      32'd0);
    push_byte(3, 1'b1, 8'h73);
    push_byte(1, 1'b1, 8'h71);
    exp_q.delete();
    exp_q.push_back({3'd1, 8'h71});
    exp_q.push_back({3'd3, 8'h73});
    wait_drain("drain_after_reset", 400);

    // Hold timeout on the second instance: requester 0 stalls, requester 3 waits.
    @(posedge clk);
    #1;
    if1.req_data  = {8'h43, 8'h00, 8'h00, 8'h40};
    if1.req_last  = 4'b1000;
    if1.req_valid = 4'b1001;
    n = 0;
    while (!if1.req_ready[0] && (n < 10)) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 if1.req_valid[0] = 1'b0;
    n = 0;
    while ((dbg1 != 2'd3) && (n < 20)) begin @(negedge clk); n++; end
    n = 0;
    while ((dbg1 != 2'd1) && (n < 30)) begin @(negedge clk); n++; end
    t0 = cyc;
    n = 0;
    while (!if1.timeout && (n < 40)) begin @(negedge clk); n++; end
    t1 = cyc;
    chk("timeout_delay", 32'(t1 - t0), 32'd20);
    chk("timeout_first_byte", 32'(t_cap), 32'h40);
    @(negedge clk);
    chk("timeout_pulse_width", 32'(if1.timeout), 32'd0);
    n = 0;
    while (!if1.req_ready[3] && (n < 10)) begin @(negedge clk); n++; end
    chk("timeout_next_owner", 32'(if1.owner), 32'd3);
    @(posedge clk);
    #1 if1.req_valid[3] = 1'b0;
    n = 0;
    while ((t_caps < 2) && (n < 100)) begin @(negedge clk); n++; end
    chk("timeout_second_byte", 32'(t_cap), 32'h43);
    repeat (20) @(negedge clk);
    chk("timeout_pulse_count", 32'(tmo_cnt1), 32'd1);
    chk("busy_after_release",  32'(if1.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
